// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronizes and debounces the A/B phases, then counts one step per accepted phase edge.
// The 32-bit position wraps modulo 2^WIDTH, and illegal double-bit transitions set a sticky error flag.
module quad_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic [WIDTH-1:0] position,
    output logic             dir,
    output logic             step,
    output logic             err
);

    // state | meaning
    // INIT  | waiting for the first stable {a,b}; it becomes the reference with no count
    // TRACK | every accepted {a,b} change is classified as up, down or illegal

    typedef enum logic {INIT, TRACK} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_UP, EV_DOWN, EV_ILL} event_t;

    localparam logic [7:0]       CNT_MAX = 8'(FILTER_LEN);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [1:0] a_sync, b_sync;
    logic [1:0] s, cand, q;
    logic [7:0] cnt;
    logic       accept;
    state_t     state;
    event_t     ev;

    assign s      = {a_sync[1], b_sync[1]};
    assign accept = (cnt == CNT_MAX) && ((state == INIT) || (cand != q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sync <= 2'b00;
            b_sync <= 2'b00;
            cand   <= 2'b00;
            cnt    <= 8'd0;
        end else begin
            a_sync <= {a_sync[0], a_in};
            b_sync <= {b_sync[0], b_in};
            if (s != cand) begin
                cand <= s;
                cnt  <= 8'd1;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // In gray order {A,B} a single-bit move is "up" exactly when old B differs from new A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            q     <= 2'b00;
            ev    <= EV_NONE;
        end else begin
            ev <= EV_NONE;
            if (accept) begin
                q <= cand;
                if (state == INIT)
                    state <= TRACK;
                else if ((cand ^ q) == 2'b11)
                    ev <= EV_ILL;
                else if (q[0] ^ cand[1])
                    ev <= EV_UP;
                else
                    ev <= EV_DOWN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            position <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
        end else begin
            step <= 1'b0;
            case (ev)
                EV_UP: begin
                    position <= position + ONE;
                    dir      <= 1'b1;
                    step     <= 1'b1;
                end
                EV_DOWN: begin
                    position <= position - ONE;
                    dir      <= 1'b0;
                    step     <= 1'b1;
                end
                EV_ILL:  err <= 1'b1;
                default: ;
            endcase
            // clr overrides the count but the step/dir report of a coincident step survives.
            if (clr) begin
                position <= '0;
                err      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a sample-history model checks every cycle and literal expectations pin key points.
module tb_quad_decoder;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_in = 1'b0;
    logic        b_in = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] position;
    logic        dir, step, err;

    int errors = 0;
    int checks = 0;
    int stepcount = 0;

    quad_decoder #(.FILTER_LEN(L), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clr(clr),
        .position(position), .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a value is accepted once it has been the input sample for L consecutive edges,
    // observed through a fixed 3-edge pipeline; its effect shows one edge after acceptance.
    function automatic int phase(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    logic [1:0]  hist[$];
    logic [1:0]  mq, v;
    bit          minit, stable;
    int          mpend, idx, d;
    logic [31:0] mpos;
    logic        mdir, mstep, merr;

    always @(posedge clk) begin
        if (!rst_n) begin
            hist  = {2'b00, 2'b00};
            minit = 1'b1;
            mq    = 2'b00;
            mpend = 0;
            mpos  = 32'd0;
            mdir  = 1'b0;
            mstep = 1'b0;
            merr  = 1'b0;
        end else begin
            mstep = 1'b0;
            case (mpend)
                1: begin mpos = mpos + 32'd1; mdir = 1'b1; mstep = 1'b1; end
                2: begin mpos = mpos - 32'd1; mdir = 1'b0; mstep = 1'b1; end
                3: merr = 1'b1;
                default: ;
            endcase
            if (clr) begin
                mpos = 32'd0;
                merr = 1'b0;
            end
            mpend = 0;
            hist.push_back({a_in, b_in});
            idx = hist.size() - 4;
            if (idx >= L - 1) begin
                v = hist[idx];
                stable = 1'b1;
                for (int k = 1; k < L; k++)
                    if (hist[idx-k] != v) stable = 1'b0;
                if (stable && (minit || v != mq)) begin
                    if (!minit) begin
                        d = (phase(v) - phase(mq)) & 3;
                        mpend = (d == 1) ? 1 : (d == 3) ? 2 : 3;
                    end
                    minit = 1'b0;
                    mq    = v;
                end
            end
        end
        #1;
        check("position", position, mpos);
        check("dir", {31'd0, dir}, {31'd0, mdir});
        check("step", {31'd0, step}, {31'd0, mstep});
        check("err", {31'd0, err}, {31'd0, merr});
        if (step === 1'b1) stepcount++;
    end

    task automatic drive(input logic [1:0] val, input int n);
        @(negedge clk);
        {a_in, b_in} = val;
        repeat (n) @(posedge clk);
        #2;
    endtask

    int sc;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(2'b00, 20);
        check("idle_pos", position, 32'd0);
        check("idle_err", {31'd0, err}, 32'd0);
        check("idle_steps", stepcount, 0);

        // first up edge with exact latency check: update lands on edge 7
        sc = stepcount;
        @(negedge clk);
        {a_in, b_in} = 2'b10;
        repeat (7) @(posedge clk);
        #2 check("lat_edge6_step", {31'd0, step}, 32'd0);
        @(posedge clk);
        #2 check("lat_edge7_step", {31'd0, step}, 32'd1);
        check("lat_edge7_pos", position, 32'd1);
        repeat (2) @(posedge clk);
        drive(2'b11, 10);
        drive(2'b01, 10);
        drive(2'b00, 10);
        check("up4_pos", position, 32'd4);
        check("up4_dir", {31'd0, dir}, 32'd1);
        check("up4_steps", stepcount - sc, 4);

        drive(2'b01, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        drive(2'b00, 10);
        check("down4_pos", position, 32'd0);
        check("down4_dir", {31'd0, dir}, 32'd0);
        drive(2'b01, 10);
        check("wrap_down_pos", position, 32'hFFFF_FFFF);
        check("wrap_down_dir", {31'd0, dir}, 32'd0);
        drive(2'b00, 10);
        check("wrap_up_pos", position, 32'd0);
        check("wrap_up_dir", {31'd0, dir}, 32'd1);

        sc = stepcount;
        drive(2'b10, 3);
        drive(2'b00, 12);
        check("glitch3_pos", position, 32'd0);
        check("glitch3_steps", stepcount - sc, 0);
        drive(2'b10, 4);
        drive(2'b00, 12);
        check("pulse4_pos", position, 32'd0);
        check("pulse4_steps", stepcount - sc, 2);

        sc = stepcount;
        drive(2'b11, 10);
        check("ill_err", {31'd0, err}, 32'd1);
        check("ill_pos", position, 32'd0);
        check("ill_steps", stepcount - sc, 0);
        drive(2'b01, 10);
        check("after_ill_pos", position, 32'd1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_err", {31'd0, err}, 32'd0);
        check("clr_pos", position, 32'd0);

        drive(2'b00, 10);
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b01, 10);
        drive(2'b00, 10);
        check("pre_collide_pos", position, 32'd5);
        @(negedge clk);
        {a_in, b_in} = 2'b10;
        repeat (7) @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #2 check("collide_pos", position, 32'd0);
        check("collide_step", {31'd0, step}, 32'd1);
        check("collide_dir", {31'd0, dir}, 32'd1);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #2 check("collide_step_end", {31'd0, step}, 32'd0);
        repeat (3) @(posedge clk);

        drive(2'b11, 10);
        check("pre_rst_pos", position, 32'd1);
        drive(2'b01, 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #2 check("rst_pos", position, 32'd0);
        check("rst_dir", {31'd0, dir}, 32'd0);
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sc = stepcount;
        drive(2'b01, 20);
        check("reinit_pos", position, 32'd0);
        check("reinit_steps", stepcount - sc, 0);
        drive(2'b00, 10);
        check("reinit_up_pos", position, 32'd1);
        check("reinit_up_err", {31'd0, err}, 32'd0);

        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
